// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that shares a bank of external SR flops between requesters.
// It issues one registered set/reset pulse per cycle and keeps a shadow copy of the bank.
module sr_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  localparam int IDXW  = $clog2(NFLAGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic [NFLAGS-1:0]      s_vec,
  output logic [NFLAGS-1:0]      r_vec,
  output logic [NFLAGS-1:0]      q_shadow,
  output logic                   err
);
  localparam int PTRW = $clog2(NREQ);

  // Handshake: a requester holds req/op/idx stable while req is high and gnt
  // is low; gnt is a one-cycle accept, after which it may change or drop req.

  logic [PTRW-1:0]   rr_ptr, ptr_nxt, win;
  logic [NREQ-1:0]   eligible, gnt_nxt;
  logic              found, idx_ok, err_nxt;
  logic [1:0]        sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic [NFLAGS-1:0] q_next, s_nxt, r_nxt;

  always_comb begin
    eligible = req & ~gnt;
    found    = 1'b0;
    win      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && eligible[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        win   = PTRW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    sel_op  = op[2*win +: 2];
    sel_idx = idx[IDXW*win +: IDXW];
    idx_ok  = {{(32-IDXW){1'b0}}, sel_idx} < NFLAGS;
    // Value the bank holds after this edge; toggles decide from it so that
    // back-to-back toggles on one flag see the pulse issued just before.
    q_next  = (q_shadow | s_vec) & ~r_vec;

    gnt_nxt = '0;
    s_nxt   = '0;
    r_nxt   = '0;
    err_nxt = 1'b0;
    ptr_nxt = rr_ptr;
    if (found) begin
      gnt_nxt[win] = 1'b1;
      ptr_nxt      = (win == PTRW'(NREQ-1)) ? '0 : win + 1'b1;
      if (sel_op == 2'b00 || !idx_ok) begin
        err_nxt = 1'b1;
      end else begin
        case (sel_op)
          2'b10:   s_nxt[sel_idx] = 1'b1;
          2'b01:   r_nxt[sel_idx] = 1'b1;
          default: begin
            if (q_next[sel_idx]) r_nxt[sel_idx] = 1'b1;
            else                 s_nxt[sel_idx] = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr   <= '0;
      gnt      <= '0;
      s_vec    <= '0;
      r_vec    <= '0;
      q_shadow <= '0;
      err      <= 1'b0;
    end else begin
      rr_ptr   <= ptr_nxt;
      gnt      <= gnt_nxt;
      s_vec    <= s_nxt;
      r_vec    <= r_nxt;
      q_shadow <= q_next;
      err      <= err_nxt;
    end
  end

endmodule
